// File: rtl/mips_top_if.sv
// mips_top bus: pipeline control, side-band preload ports
// and the IF/ID and EX debug outputs.
interface mips_top_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               i_enable;
  logic [NB_ADDR-1:0] i_pc;
  logic               i_write;
  logic [NB_ADDR-1:0] i_address;
  logic [NB_INST-1:0] i_instruction;
  logic               i_id_write;
  logic [NB_REG-1:0]  i_address_data;
  logic [NB_DATA-1:0] i_data_input;
  logic [NB_INST-1:0] o_instruction;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_DATA-1:0] o_alu_result;

  modport master (
    output i_enable, i_pc,
    output i_write, i_address, i_instruction,
    output i_id_write, i_address_data, i_data_input,
    input  o_instruction, o_pc, o_alu_result
  );

  modport slave (
    input  i_enable, i_pc,
    input  i_write, i_address, i_instruction,
    input  i_id_write, i_address_data, i_data_input,
    output o_instruction, o_pc, o_alu_result
  );
endinterface

// File: rtl/mips_top.sv
// MIPS front end: PC, IF, ID, EX with IF/ID and ID/EX regs.
// Imem and regfile are preloaded through side-band writes.
module mips_top #(
  parameter int NB_ADDR    = 32,
  parameter int NB_INST    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int IMEM_DEPTH = 64
) (
  input  logic     i_clk,
  input  logic     i_reset,
  mips_top_if.slave bus
);

  localparam int AW    = $clog2(IMEM_DEPTH);
  localparam int NREGS = 1 << NB_REG;

  typedef enum logic [3:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_AND,
    OP_OR,   OP_XOR, OP_NOR, OP_SLT,
    OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
    OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI
  } alu_op_e;

  typedef struct packed {
    logic [NB_INST-1:0] inst;
    logic [NB_ADDR-1:0] pc;
  } if_id_t;

  typedef struct packed {
    logic [NB_DATA-1:0] rs_val;
    logic [NB_DATA-1:0] rt_val;
    logic [NB_DATA-1:0] imm;
    logic [4:0]         shamt;
    alu_op_e            op;
    logic               alu_src;
  } id_ex_t;

  logic [NB_ADDR-1:0] pc_q;
  if_id_t             if_id_q, if_id_d;
  id_ex_t             id_ex_q, id_ex_d;
  logic [NB_INST-1:0] imem_q [IMEM_DEPTH];
  logic [NB_DATA-1:0] rf_q [NREGS];
  logic [NB_DATA-1:0] alu_res;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_address[NB_ADDR-1:AW],
                              pc_q[NB_ADDR-1:AW]};

  // Instruction memory preload; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && bus.i_write)
      imem_q[bus.i_address[AW-1:0]] <= bus.i_instruction;
  end

  // Register file: cleared by reset, r0 writes dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (bus.i_id_write && bus.i_address_data != '0) begin
      rf_q[bus.i_address_data] <= bus.i_data_input;
    end
  end

  // Register read with write-first bypass; r0 is hardwired.
  function automatic logic [NB_DATA-1:0] rf_read(
    input logic [NB_REG-1:0] idx
  );
    if (idx == '0)
      return '0;
    if (bus.i_id_write && bus.i_address_data == idx)
      return bus.i_data_input;
    return rf_q[idx];
  endfunction

  // Fetch: asynchronous imem read at the current PC.
  always_comb begin
    if_id_d.inst = imem_q[pc_q[AW-1:0]];
    if_id_d.pc   = pc_q;
  end

  // Decode: operand read, immediate extension, ALU op select.
  always_comb begin
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [15:0] imm;
    opc = if_id_q.inst[31:26];
    fn  = if_id_q.inst[5:0];
    imm = if_id_q.inst[15:0];
    id_ex_d         = '0;
    id_ex_d.rs_val  = rf_read(if_id_q.inst[25:21]);
    id_ex_d.rt_val  = rf_read(if_id_q.inst[20:16]);
    id_ex_d.shamt   = if_id_q.inst[10:6];
    id_ex_d.op      = OP_NONE;
    id_ex_d.alu_src = 1'b0;
    id_ex_d.imm     = {{16{imm[15]}}, imm};
    unique case (opc)
      6'b000000: begin
        unique case (fn)
          6'b100000, 6'b100001: id_ex_d.op = OP_ADD;
          6'b100010, 6'b100011: id_ex_d.op = OP_SUB;
          6'b100100: id_ex_d.op = OP_AND;
          6'b100101: id_ex_d.op = OP_OR;
          6'b100110: id_ex_d.op = OP_XOR;
          6'b100111: id_ex_d.op = OP_NOR;
          6'b101010: id_ex_d.op = OP_SLT;
          6'b101011: id_ex_d.op = OP_SLTU;
          6'b000000: id_ex_d.op = OP_SLL;
          6'b000010: id_ex_d.op = OP_SRL;
          6'b000011: id_ex_d.op = OP_SRA;
          6'b000100: id_ex_d.op = OP_SLLV;
          6'b000110: id_ex_d.op = OP_SRLV;
          6'b000111: id_ex_d.op = OP_SRAV;
          default:   id_ex_d.op = OP_NONE;
        endcase
      end
      6'b001000, 6'b001001: begin
        id_ex_d.op      = OP_ADD;
        id_ex_d.alu_src = 1'b1;
      end
      6'b001010: begin
        id_ex_d.op      = OP_SLT;
        id_ex_d.alu_src = 1'b1;
      end
      6'b001011: begin
        id_ex_d.op      = OP_SLTU;
        id_ex_d.alu_src = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        id_ex_d.imm     = {16'h0, imm};
        id_ex_d.alu_src = 1'b1;
        unique case (opc[1:0])
          2'b00:   id_ex_d.op = OP_AND;
          2'b01:   id_ex_d.op = OP_OR;
          default: id_ex_d.op = OP_XOR;
        endcase
      end
      6'b001111: begin
        id_ex_d.imm     = {imm, 16'h0};
        id_ex_d.op      = OP_LUI;
        id_ex_d.alu_src = 1'b1;
      end
      default: id_ex_d.op = OP_NONE;
    endcase
  end

  // Pipeline registers: reset dominates, hold when disabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= '0;
      if_id_q <= '0;
      id_ex_q <= '0;
    end else if (bus.i_enable) begin
      pc_q    <= bus.i_pc;
      if_id_q <= if_id_d;
      id_ex_q <= id_ex_d;
    end
  end

  // Execute: combinational ALU on the ID/EX bundle.
  always_comb begin
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_DATA-1:0] t;
    a = id_ex_q.rs_val;
    t = id_ex_q.rt_val;
    b = id_ex_q.alu_src ? id_ex_q.imm : t;
    alu_res = '0;
    unique case (id_ex_q.op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}},
                          $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, a < b};
      OP_SLL:  alu_res = t << id_ex_q.shamt;
      OP_SRL:  alu_res = t >> id_ex_q.shamt;
      OP_SRA:  alu_res = $unsigned($signed(t) >>> id_ex_q.shamt);
      OP_SLLV: alu_res = t << a[4:0];
      OP_SRLV: alu_res = t >> a[4:0];
      OP_SRAV: alu_res = $unsigned($signed(t) >>> a[4:0]);
      OP_LUI:  alu_res = b;
      default: alu_res = '0;
    endcase
  end

  assign bus.o_instruction = if_id_q.inst;
  assign bus.o_pc          = if_id_q.pc;
  assign bus.o_alu_result  = alu_res;

endmodule

// File: tb/tb_mips_top.sv
// Self-checking bench for mips_top: directed scenarios plus
// randomized traffic against an instruction-level model.
module tb_mips_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_top_if bus ();

  mips_top dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] imem_m [64];
  logic [31:0] regs_m [32];
  logic [31:0] m_pc, m_inst, m_ipc, m_res;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] inst,
    input logic [31:0] a,
    input logic [31:0] t
  );
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] se;
    logic [31:0] ze;
    int          sa, sb;
    opc = inst[31:26];
    fn  = inst[5:0];
    sh  = inst[10:6];
    ze  = {16'h0, inst[15:0]};
    se  = {{16{inst[15]}}, inst[15:0]};
    sa  = a;
    if (opc == 6'd0) begin
      sb = t;
      case (fn)
        6'd32, 6'd33: return a + t;
        6'd34, 6'd35: return a - t;
        6'd36: return a & t;
        6'd37: return a | t;
        6'd38: return a ^ t;
        6'd39: return ~(a | t);
        6'd42: return (sa < sb) ? 32'd1 : 32'd0;
        6'd43: return (a < t) ? 32'd1 : 32'd0;
        6'd0:  return t << sh;
        6'd2:  return t >> sh;
        6'd3:  return 32'($signed(t) >>> sh);
        6'd4:  return t << a[4:0];
        6'd6:  return t >> a[4:0];
        6'd7:  return 32'($signed(t) >>> a[4:0]);
        default: return 32'd0;
      endcase
    end
    sb = se;
    case (opc)
      6'd8, 6'd9: return a + se;
      6'd10: return (sa < sb) ? 32'd1 : 32'd0;
      6'd11: return (a < se) ? 32'd1 : 32'd0;
      6'd12: return a & ze;
      6'd13: return a | ze;
      6'd14: return a ^ ze;
      6'd15: return {inst[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.i_id_write && bus.i_address_data == r)
      return bus.i_data_input;
    return regs_m[r];
  endfunction

  task automatic model_edge();
    logic [31:0] n_res;
    if (rst) begin
      m_pc = 0; m_inst = 0; m_ipc = 0; m_res = 0;
      for (int i = 0; i < 32; i++) regs_m[i] = 0;
      return;
    end
    if (bus.i_enable) begin
      n_res  = ref_alu(m_inst, ref_rd(m_inst[25:21]),
                       ref_rd(m_inst[20:16]));
      m_res  = n_res;
      m_ipc  = m_pc;
      m_inst = imem_m[m_pc % 64];
      m_pc   = bus.i_pc;
    end
    if (bus.i_write)
      imem_m[bus.i_address % 64] = bus.i_instruction;
    if (bus.i_id_write && bus.i_address_data != 0)
      regs_m[bus.i_address_data] = bus.i_data_input;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_enable = 0; bus.i_pc = 0;
    bus.i_write = 0; bus.i_address = 0; bus.i_instruction = 0;
    bus.i_id_write = 0; bus.i_address_data = 0;
    bus.i_data_input = 0;
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] d);
    bus.i_id_write = 1; bus.i_address_data = r;
    bus.i_data_input = d;
    step();
    bus.i_id_write = 0;
  endtask

  task automatic wr_imem(input logic [31:0] a, input logic [31:0] d);
    bus.i_write = 1; bus.i_address = a; bus.i_instruction = d;
    step();
    bus.i_write = 0;
  endtask

  // Load PC with a, then let it flow through IF/ID and ID/EX.
  task automatic run_pc(input logic [31:0] a);
    bus.i_enable = 1; bus.i_pc = a;
    step(); step(); step();
    bus.i_enable = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if (bus.o_instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_inst got %h want 0", bus.o_instruction);
    end
    n_checks++;
    if (bus.o_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc got %h want 0", bus.o_pc);
    end
    n_checks++;
    if (bus.o_alu_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_alu got %h want 0", bus.o_alu_result);
    end
  endtask

  task automatic test_add();
    wr_reg(1, 1);
    wr_reg(2, 2);
    wr_imem(1, 32'h00201020);
    bus.i_enable = 1; bus.i_pc = 1;
    step(); step();
    n_checks++;
    if (bus.o_instruction !== 32'h00201020) begin
      n_fail++;
      $display("FAIL add_inst got %h want 00201020",
               bus.o_instruction);
    end
    n_checks++;
    if (bus.o_pc !== 32'd1) begin
      n_fail++;
      $display("FAIL add_pc got %h want 1", bus.o_pc);
    end
    step();
    n_checks++;
    if (bus.o_alu_result !== 32'd1) begin
      n_fail++;
      $display("FAIL add_alu got %h want 1", bus.o_alu_result);
    end
    bus.i_enable = 0;
  endtask

  task automatic test_sub_slt();
    wr_imem(2, 32'h00221822);
    wr_imem(3, 32'h0022182A);
    wr_imem(4, 32'h0041182B);
    run_pc(2);
    n_checks++;
    if (bus.o_alu_result !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL sub got %h want ffffffff", bus.o_alu_result);
    end
    run_pc(3);
    n_checks++;
    if (bus.o_alu_result !== 32'd1) begin
      n_fail++;
      $display("FAIL slt got %h want 1", bus.o_alu_result);
    end
    run_pc(4);
    n_checks++;
    if (bus.o_alu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL sltu got %h want 0", bus.o_alu_result);
    end
  endtask

  task automatic test_stall();
    bus.i_enable = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.i_pc = i;
      step();
    end
    bus.i_enable = 0;
    bus.i_pc = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.o_pc !== 32'd3 || bus.o_instruction !== 32'h0022182A
          || bus.o_alu_result !== 32'hFFFFFFFF) begin
        n_fail++;
        $display("FAIL stall_hold pc %h inst %h alu %h want 3 0022182a ffffffff",
                 bus.o_pc, bus.o_instruction, bus.o_alu_result);
      end
    end
    bus.i_enable = 1; bus.i_pc = 1;
    step();
    n_checks++;
    if (bus.o_pc !== 32'd4 || bus.o_alu_result !== 32'd1) begin
      n_fail++;
      $display("FAIL stall_resume pc %h alu %h want 4 1",
               bus.o_pc, bus.o_alu_result);
    end
    bus.i_enable = 0;
  endtask

  task automatic test_r0_write();
    wr_reg(0, 32'hDEADBEEF);
    wr_imem(5, 32'h00002020);
    run_pc(5);
    n_checks++;
    if (bus.o_alu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write got %h want 0", bus.o_alu_result);
    end
  endtask

  task automatic test_lui_ori();
    wr_imem(6, 32'h3C051234);
    wr_imem(7, 32'h3426FFFF);
    run_pc(6);
    n_checks++;
    if (bus.o_alu_result !== 32'h12340000) begin
      n_fail++;
      $display("FAIL lui got %h want 12340000", bus.o_alu_result);
    end
    run_pc(32'h0000_0047);
    n_checks++;
    if (bus.o_alu_result !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL ori_wrap got %h want 0000ffff",
               bus.o_alu_result);
    end
  endtask

  logic [5:0] fn_tab [15] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                              6'd37, 6'd38, 6'd39, 6'd42, 6'd43,
                              6'd0, 6'd2, 6'd3, 6'd4, 6'd7};
  logic [5:0] op_tab [8]  = '{6'd8, 6'd9, 6'd10, 6'd11,
                              6'd12, 6'd13, 6'd14, 6'd15};

  function automatic logic [31:0] rand_inst();
    int          k;
    logic [31:0] w;
    k = $urandom_range(0, 24);
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    if (k < 15) begin
      w[31:26] = 0;
      w[5:0]   = fn_tab[k];
    end else if (k < 23) begin
      w[31:26] = op_tab[k-15];
    end
    return w;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 64; i++) wr_imem(i, rand_inst());
    for (int r = 1; r < 8; r++) begin
      logic [31:0] d;
      d = $urandom;
      if (r == 7) d = 32'h80000000;
      wr_reg(5'(r), d);
    end
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.i_enable = ($urandom_range(0, 3) != 0);
      bus.i_pc = $urandom;
      bus.i_write = ($urandom_range(0, 4) == 0);
      bus.i_address = $urandom;
      bus.i_instruction = rand_inst();
      bus.i_id_write = ($urandom_range(0, 2) == 0);
      bus.i_address_data = 5'($urandom_range(0, 7));
      bus.i_data_input = $urandom;
      step();
      n_checks++;
      if (bus.o_instruction !== m_inst || bus.o_pc !== m_ipc
          || bus.o_alu_result !== m_res) begin
        n_fail++;
        $display("FAIL rand_c%0d got inst %h pc %h alu %h want %h %h %h",
                 c, bus.o_instruction, bus.o_pc, bus.o_alu_result,
                 m_inst, m_ipc, m_res);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    wr_reg(1, 32'hFFFFFFF0);
    wr_reg(2, 32'd4);
    wr_imem(10, 32'h00221821);
    wr_imem(11, 32'h00021883);
    wr_imem(12, 32'h2823FFFF);
    bus.i_enable = 1;
    for (int i = 10; i < 16; i++) begin
      bus.i_pc = i;
      step();
      if (i >= 12) begin
        n_checks++;
        if (bus.o_alu_result !== m_res) begin
          n_fail++;
          $display("FAIL b2b_%0d got %h want %h",
                   i, bus.o_alu_result, m_res);
        end
      end
    end
    bus.i_enable = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem_m[i] = 'x;
    m_pc = 0; m_inst = 0; m_ipc = 0; m_res = 0;
    idle_inputs();
    for (int i = 0; i < 64; i++) wr_imem(i, 32'h0);
    test_reset();
    test_add();
    test_sub_slt();
    test_stall();
    test_r0_write();
    test_lui_ori();
    test_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
